// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle radix-2 restoring divider for the E stage (DIV/DIVU).
//
// An operation starts from IDLE when a divide is present in E and is not being
// annulled. The operand magnitudes are latched at that point. The unit then
// runs WIDTH restoring steps in BUSY, applies sign correction and loads the
// result as it enters DONE. While the divide is in progress it holds the
// front of the pipeline with stall_div. In DONE that stall is released, so the
// divide instruction leaves E in the same cycle that ready is high.
//
// Handshake: start is a level that the pipeline holds while it is stalled.
// ready is a one-cycle pulse, and result is valid in that cycle. result keeps
// its value until the next divide completes. Only the IDLE->BUSY edge samples
// operands. start is ignored in DONE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   divide instruction present in E
//   signed_div in   1 = DIV (two's complement), 0 = DIVU
//   a, b       in   dividend / divisor (WIDTH)
//   annul      in   cancel the in-flight or starting operation
//   stall_div  out  stall request to the hazard unit (combinational)
//   ready      out  registered one-cycle result-valid pulse
//   result     out  {remainder, quotient} (2*WIDTH), goes to {HI, LO}
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   div_q, div_d;       // |divisor|
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;       // dividend bits shifting out, quotient bits shifting in
    logic               a_sign_q, a_sign_d; // remainder takes the dividend's sign
    logic               q_sign_q, q_sign_d;
    logic               dz_q, dz_d;         // divide by zero
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    // Operand magnitudes for the start edge
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // One restoring step
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   fix_rem, fix_quo;

    assign a_neg = signed_div & a[WIDTH-1];
    assign b_neg = signed_div & b[WIDTH-1];
    assign mag_a = a_neg ? (~a + 1'b1) : a;
    assign mag_b = b_neg ? (~b + 1'b1) : b;

    // The partial remainder is always below the divisor, so a WIDTH+1 bit
    // window holds the shifted value. Bit WIDTH of the difference is its sign.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, div_q};
    assign step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    // With a zero divisor, every trial subtract succeeds. The quotient comes
    // out as all ones and the remainder as |a|. Sign correction of the
    // remainder then restores the original a. The quotient sign is not
    // applied, so the quotient stays all ones.
    assign fix_rem = a_sign_q ? (~step_rem + 1'b1) : step_rem;
    assign fix_quo = (q_sign_q & ~dz_q) ? (~step_quo + 1'b1) : step_quo;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        a_sign_d = a_sign_q;
        q_sign_d = q_sign_q;
        dz_d     = dz_q;
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    div_d    = mag_b;
                    quo_d    = mag_a;
                    rem_d    = '0;
                    a_sign_d = a_neg;
                    q_sign_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    dz_d     = (b == '0);
                end
            end
            BUSY: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = {fix_rem, fix_quo};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            a_sign_q <= 1'b0;
            q_sign_q <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            a_sign_q <= a_sign_d;
            q_sign_q <= q_sign_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // The stall is released in DONE, so the pipeline advances in the ready cycle.
    assign stall_div = ~rst & ~annul &
                       (((state_q == IDLE) & start) | (state_q == BUSY));
    assign ready     = ready_q;
    assign result    = result_q;

endmodule
